// File: rtl/elastic_pkg.sv
// Shared helpers for the elastic FIFO family: storage/occupancy widths and the handshake fire term.
package elastic_pkg;

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic hs_fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/elastic_ptr_wrap.sv
// Modulo-DEPTH pointer: advances on en, wraps to 0 after DEPTH-1, cleared by flush.
module elastic_ptr_wrap #(
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          en,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_next;

    // Explicit compare keeps non-power-of-two depths exact without a modulo.
    assign ptr_next = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (flush) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/elastic_fifo_counted.sv
// Valid/ready FIFO with arbitrary depth, occupancy count, registered almost flags and flush.
// Optional zero-latency bypass on an empty FIFO when FIFO_BYPASS_EN is defined.
module elastic_fifo_counted
    import elastic_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [DATA_WIDTH-1:0]                data_in,
    input  logic                                 valid_in,
    output logic                                 ready_in,
    output logic [DATA_WIDTH-1:0]                data_out,
    output logic                                 valid_out,
    input  logic                                 ready_out,
    output logic [count_width(FIFO_DEPTH)-1:0]   count,
    output logic                                 almost_full,
    output logic                                 almost_empty
);

    localparam int PW = ptr_width(FIFO_DEPTH);
    localparam int CW = count_width(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_next;
    logic                  not_empty;
    logic                  full;
    logic                  bypass;
    logic                  wr_en;
    logic                  rd_en;
    logic                  push;
    logic                  pop;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == CW'(FIFO_DEPTH));

`ifdef FIFO_BYPASS_EN
    assign bypass    = ~not_empty & valid_in & ready_out & ~flush;
    assign valid_out = (not_empty & ~flush) | bypass;
    assign data_out  = bypass ? data_in : mem[head];
`else
    assign bypass    = 1'b0;
    assign valid_out = not_empty & ~flush;
    assign data_out  = mem[head];
`endif

    // A full FIFO still accepts when the consumer drains the head this cycle.
    assign ready_in = ~flush & (~full | ready_out);
    assign wr_en    = hs_fire(valid_in, ready_in);
    assign rd_en    = hs_fire(valid_out, ready_out);

    // A bypassed word handshakes on both sides but never touches storage.
    assign push = wr_en & ~bypass;
    assign pop  = rd_en & ~bypass;

    always_comb begin
        count_next = count_q;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_q + CW'(1);
        end else if (pop && !push) begin
            count_next = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count_q      <= count_next;
            almost_full  <= (count_next >= CW'(AF_THRESH));
            almost_empty <= (count_next <= CW'(AE_THRESH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= data_in;
        end
    end

    assign count = count_q;

    elastic_ptr_wrap #(
        .DEPTH (FIFO_DEPTH),
        .PW    (PW)
    ) u_head (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .en    (pop),
        .ptr   (head)
    );

    elastic_ptr_wrap #(
        .DEPTH (FIFO_DEPTH),
        .PW    (PW)
    ) u_tail (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .en    (push),
        .ptr   (tail)
    );

endmodule

// File: tb/tb_elastic_fifo_counted.sv
// Bench for elastic_fifo_counted: depth-8 and depth-5 instances checked against a queue scoreboard.
module tb_elastic_fifo_counted;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_flush, b_flush;
    logic [7:0] a_din, a_dout, b_din, b_dout;
    logic       a_vin, a_rin, a_vout, a_rout;
    logic       b_vin, b_rin, b_vout, b_rout;
    logic [3:0] a_count;
    logic [2:0] b_count;
    logic       a_af, a_ae, b_af, b_ae;

    int total = 0;
    int bad   = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    always #5 clk = ~clk;

    elastic_fifo_counted #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .data_in(a_din), .valid_in(a_vin), .ready_in(a_rin),
        .data_out(a_dout), .valid_out(a_vout), .ready_out(a_rout),
        .count(a_count), .almost_full(a_af), .almost_empty(a_ae)
    );

    elastic_fifo_counted #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .data_in(b_din), .valid_in(b_vin), .ready_in(b_rin),
        .data_out(b_dout), .valid_out(b_vout), .ready_out(b_rout),
        .count(b_count), .almost_full(b_af), .almost_empty(b_ae)
    );

    // One clock of DUT A: account handshakes at the falling edge, then check occupancy after the rise.
    task automatic cyc_a();
        logic [7:0] exp;
        @(negedge clk);
        if (a_vin && a_rin) q_a.push_back(a_din);
        if (a_vout && a_rout) begin
            total++;
            if (q_a.size() == 0) begin
                bad++;
                $display("FAIL a_read_order: got %h, expected no read", a_dout);
            end else begin
                exp = q_a.pop_front();
                if (a_dout !== exp) begin
                    bad++;
                    $display("FAIL a_read_order: got %h, expected %h", a_dout, exp);
                end
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (a_count !== 4'(q_a.size())) begin
            bad++;
            $display("FAIL a_count_model: got %0d, expected %0d", a_count, q_a.size());
        end
    endtask

    task automatic cyc_b();
        logic [7:0] exp;
        @(negedge clk);
        if (b_vin && b_rin) q_b.push_back(b_din);
        if (b_vout && b_rout) begin
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL b_read_order: got %h, expected no read", b_dout);
            end else begin
                exp = q_b.pop_front();
                if (b_dout !== exp) begin
                    bad++;
                    $display("FAIL b_read_order: got %h, expected %h", b_dout, exp);
                end
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (b_count !== 3'(q_b.size()) || b_count > 3'd5) begin
            bad++;
            $display("FAIL b_count_model: got %0d, expected %0d", b_count, q_b.size());
        end
        total++;
        if (b_af !== (q_b.size() >= 4) || b_ae !== (q_b.size() <= 1)) begin
            bad++;
            $display("FAIL b_flags: got af=%b ae=%b, expected af=%b ae=%b",
                     b_af, b_ae, q_b.size() >= 4, q_b.size() <= 1);
        end
    endtask

    task automatic drain_a();
        a_vin  = 1'b0;
        a_rout = 1'b1;
        for (int i = 0; i < 20 && q_a.size() != 0; i++) cyc_a();
        a_rout = 1'b0;
        total++;
        if (a_count !== 4'd0) begin
            bad++;
            $display("FAIL a_drain: got count %0d, expected 0", a_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_flush = 0; a_din = 0; a_vin = 0; a_rout = 0;
        b_flush = 0; b_din = 0; b_vin = 0; b_rout = 0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (a_count !== 4'd0 || a_vout !== 1'b0 || a_rin !== 1'b1 || a_af !== 1'b0 || a_ae !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: got count=%0d vout=%b rin=%b af=%b ae=%b, expected 0 0 1 0 1",
                     a_count, a_vout, a_rin, a_af, a_ae);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_drain();
        a_rout = 1'b0;
        a_vin  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_din = 8'h10 + 8'(i);
            cyc_a();
            total++;
            if (a_count !== 4'(i + 1) || a_af !== (i + 1 >= 7) || a_ae !== (i + 1 <= 1)) begin
                bad++;
                $display("FAIL fill_flags: got count=%0d af=%b ae=%b, expected count=%0d af=%b ae=%b",
                         a_count, a_af, a_ae, i + 1, i + 1 >= 7, i + 1 <= 1);
            end
        end
        total++;
        if (a_rin !== 1'b0) begin
            bad++;
            $display("FAIL full_ready: got ready_in=%b, expected 0", a_rin);
        end
        drain_a();
        total++;
        if (a_ae !== 1'b1 || a_af !== 1'b0) begin
            bad++;
            $display("FAIL drained_flags: got af=%b ae=%b, expected 0 1", a_af, a_ae);
        end
    endtask

    task automatic test_full_rw();
        a_rout = 1'b0;
        a_vin  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_din = 8'h40 + 8'(i);
            cyc_a();
        end
        a_rout = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_din = 8'h60 + 8'(i);
            #1;
            total++;
            if (a_rin !== 1'b1 || a_vout !== 1'b1) begin
                bad++;
                $display("FAIL full_rw_hs: got rin=%b vout=%b, expected 1 1", a_rin, a_vout);
            end
            cyc_a();
            total++;
            if (a_count !== 4'd8) begin
                bad++;
                $display("FAIL full_rw_count: got %0d, expected 8", a_count);
            end
        end
        drain_a();
    endtask

    task automatic test_flush();
        a_rout = 1'b0;
        a_vin  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_din = 8'h70 + 8'(i);
            cyc_a();
        end
        a_flush = 1'b1;
        a_din   = 8'hEE;
        @(negedge clk);
        total++;
        if (a_rin !== 1'b0 || a_vout !== 1'b0) begin
            bad++;
            $display("FAIL flush_cycle: got rin=%b vout=%b, expected 0 0", a_rin, a_vout);
        end
        @(posedge clk);
        #1;
        a_flush = 1'b0;
        a_vin   = 1'b0;
        q_a.delete();
        total++;
        if (a_count !== 4'd0 || a_vout !== 1'b0) begin
            bad++;
            $display("FAIL flush_after: got count=%0d vout=%b, expected 0 0", a_count, a_vout);
        end
        a_vin = 1'b1;
        a_din = 8'h33;
        cyc_a();
        drain_a();
    endtask

    task automatic test_async_reset();
        a_rout = 1'b0;
        a_vin  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_din = 8'h80 + 8'(i);
            cyc_a();
        end
        a_vin = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        q_a.delete();
        total++;
        if (a_count !== 4'd0 || a_vout !== 1'b0 || a_rin !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: got count=%0d vout=%b rin=%b, expected 0 0 1", a_count, a_vout, a_rin);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        a_vin = 1'b1;
        a_din = 8'hAA;
        cyc_a();
        a_vin = 1'b0;
        #1;
        total++;
        if (a_vout !== 1'b1 || a_dout !== 8'hAA) begin
            bad++;
            $display("FAIL reset_readback: got vout=%b data=%h, expected 1 aa", a_vout, a_dout);
        end
        drain_a();
    endtask

    task automatic test_latency();
        a_vin  = 1'b1;
        a_rout = 1'b1;
        a_din  = 8'h55;
        #1;
`ifdef FIFO_BYPASS_EN
        total++;
        if (a_vout !== 1'b1 || a_dout !== 8'h55) begin
            bad++;
            $display("FAIL bypass_same_cycle: got vout=%b data=%h, expected 1 55", a_vout, a_dout);
        end
        cyc_a();
        total++;
        if (a_count !== 4'd0) begin
            bad++;
            $display("FAIL bypass_count: got %0d, expected 0", a_count);
        end
`else
        total++;
        if (a_vout !== 1'b0) begin
            bad++;
            $display("FAIL no_comb_path: got vout=%b, expected 0", a_vout);
        end
        cyc_a();
        #1;
        total++;
        if (a_vout !== 1'b1 || a_dout !== 8'h55) begin
            bad++;
            $display("FAIL one_cycle_latency: got vout=%b data=%h, expected 1 55", a_vout, a_dout);
        end
`endif
        a_vin = 1'b0;
        drain_a();
    endtask

    task automatic test_stream_wrap();
        int sent = 0;
        int cycles = 0;
        while ((sent < 20 || q_b.size() != 0) && cycles < 500) begin
            b_vin  = (sent < 20) && ($urandom_range(0, 3) != 0);
            b_rout = ($urandom_range(0, 3) != 0);
            b_din  = 8'hC0 + 8'(sent);
            #1;
            if (b_vin && b_rin) sent++;
            cyc_b();
            cycles++;
        end
        b_vin  = 1'b0;
        b_rout = 1'b0;
        total++;
        if (sent != 20 || q_b.size() != 0) begin
            bad++;
            $display("FAIL stream_timeout: got sent=%0d pending=%0d, expected 20 0", sent, q_b.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_flush();
        test_async_reset();
        test_latency();
        test_stream_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
